// File: rtl/count_ctrl_pkg.sv
// Shared types for the count session controller: session FSM states, event
// direction codes and the round-robin pointer encoding.
`timescale 1ns/1ps
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } sess_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Pointer names the requester that wins the next tie.
    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } arb_ptr_t;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational one-hot grant from the current
// pointer; the pointer flips to the other requester whenever advance is high.
`timescale 1ns/1ps
module rr_arb2
    import count_ctrl_pkg::*;
(
    input  logic       Clk100M,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    arb_ptr_t ptr_q;

    always_ff @(posedge Clk100M or posedge reset) begin
        if (reset) begin
            ptr_q <= PTR_A;
        end else if (advance) begin
            ptr_q <= grant[REQ_A] ? PTR_B : PTR_A;
        end
    end

    always_comb begin
        grant = 2'b00;
        if (ptr_q == PTR_A) begin
            if (req[REQ_A])      grant[REQ_A] = 1'b1;
            else if (req[REQ_B]) grant[REQ_B] = 1'b1;
        end else begin
            if (req[REQ_B])      grant[REQ_B] = 1'b1;
            else if (req[REQ_A]) grant[REQ_A] = 1'b1;
        end
    end

endmodule

// File: rtl/count_session_ctrl.sv
// Session controller and A/B arbiter for the up/down user counter, with a
// saturating shadow count. Define SESSION_TIMEOUT_EN to enable the idle auto-stop.
`timescale 1ns/1ps
module count_session_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MAX_COUNT = 255
`ifdef SESSION_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 100000000
`endif
) (
    input  logic             Clk100M,
    input  logic             reset,
    input  logic             sess_start,
    input  logic             sess_stop,
    input  logic             a_req,
    input  logic             a_dir,
    output logic             a_ack,
    input  logic             b_req,
    input  logic             b_dir,
    output logic             b_ack,
    output logic             ctr_start,
    output logic             ctr_stop,
    output logic             ctr_up,
    output logic             ctr_down,
    output logic [CNT_W-1:0] sess_count,
    output logic [1:0]       state,
    output logic             evt_rej,
    output logic             timed_out
);

    sess_state_t      state_q, state_d;
    logic             start_go, stop_go, tmo_go, end_go, grant_en;
    logic [1:0]       arb_req, grant;
    logic             dir_sel;
    logic             a_ack_d, b_ack_d, ctr_start_d, ctr_stop_d;
    logic             ctr_up_d, ctr_down_d, evt_rej_d;
    logic [CNT_W-1:0] count_d;

    assign start_go = (state_q == IDLE || state_q == DONE) && sess_start;
    assign stop_go  = (state_q == ACTIVE) && sess_stop;
    assign end_go   = stop_go | tmo_go;
    assign state    = state_q;

    // Handshake: a requester holds req (and a stable dir) until it sees a
    // one-cycle ack; the acking cycle masks that req so it is never granted twice.
    assign grant_en = (state_q == IDLE) || (state_q == DONE) ||
                      ((state_q == ACTIVE) && !end_go);
    assign arb_req  = {b_req & ~b_ack, a_req & ~a_ack} & {2{grant_en}};

    rr_arb2 u_arb (
        .Clk100M (Clk100M),
        .reset   (reset),
        .req     (arb_req),
        .advance (|grant),
        .grant   (grant)
    );

    always_ff @(posedge Clk100M or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_go) state_d = ARMED;
            ARMED:      state_d = ACTIVE;
            ACTIVE:     if (end_go) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Events outside ACTIVE, or that would push the shadow count past a bound,
    // are still acked so requesters never stall, but flagged as rejected.
    always_comb begin
        a_ack_d     = grant[REQ_A];
        b_ack_d     = grant[REQ_B];
        ctr_start_d = start_go;
        ctr_stop_d  = end_go;
        ctr_up_d    = 1'b0;
        ctr_down_d  = 1'b0;
        evt_rej_d   = 1'b0;
        count_d     = sess_count;
        dir_sel     = grant[REQ_B] ? b_dir : a_dir;
        if (|grant) begin
            if (state_q != ACTIVE) begin
                evt_rej_d = 1'b1;
            end else if (dir_sel == DIR_UP) begin
                if (sess_count == CNT_W'(MAX_COUNT)) begin
                    evt_rej_d = 1'b1;
                end else begin
                    ctr_up_d = 1'b1;
                    count_d  = sess_count + CNT_W'(1);
                end
            end else if (dir_sel == DIR_DOWN) begin
                if (sess_count == '0) begin
                    evt_rej_d = 1'b1;
                end else begin
                    ctr_down_d = 1'b1;
                    count_d    = sess_count - CNT_W'(1);
                end
            end
        end
        if (start_go) count_d = '0;
    end

    always_ff @(posedge Clk100M or posedge reset) begin
        if (reset) begin
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            ctr_start  <= 1'b0;
            ctr_stop   <= 1'b0;
            ctr_up     <= 1'b0;
            ctr_down   <= 1'b0;
            evt_rej    <= 1'b0;
            sess_count <= '0;
        end else begin
            a_ack      <= a_ack_d;
            b_ack      <= b_ack_d;
            ctr_start  <= ctr_start_d;
            ctr_stop   <= ctr_stop_d;
            ctr_up     <= ctr_up_d;
            ctr_down   <= ctr_down_d;
            evt_rej    <= evt_rej_d;
            sess_count <= count_d;
        end
    end

`ifdef SESSION_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer_q;
    logic             timed_out_q;

    assign tmo_go    = (state_q == ACTIVE) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign timed_out = timed_out_q;

    // Only accepted events count as activity; rejected ones let the timer run.
    always_ff @(posedge Clk100M or posedge reset) begin
        if (reset) begin
            timer_q     <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (start_go || ctr_up_d || ctr_down_d) timer_q <= '0;
            else if (state_q == ACTIVE)             timer_q <= timer_q + TMR_W'(1);
            if (start_go)                   timed_out_q <= 1'b0;
            else if (tmo_go && !stop_go)    timed_out_q <= 1'b1;
        end
    end
`else
    assign tmo_go    = 1'b0;
    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_count_session_ctrl.sv
// Directed testbench for count_session_ctrl; covers the timeout path when
// SESSION_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_count_session_ctrl;
    import count_ctrl_pkg::*;

    localparam int CNT_W     = 8;
    localparam int MAX_COUNT = 255;
    localparam int TMO_CYC   = 16;

    logic             Clk100M = 1'b0;
    logic             reset = 1'b1;
    logic             sess_start = 1'b0, sess_stop = 1'b0;
    logic             a_req = 1'b0, a_dir = 1'b0, b_req = 1'b0, b_dir = 1'b0;
    logic             a_ack, b_ack, ctr_start, ctr_stop, ctr_up, ctr_down;
    logic [CNT_W-1:0] sess_count;
    logic [1:0]       state;
    logic             evt_rej, timed_out;
    logic [6:0]       pulses;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    assign pulses = {a_ack, b_ack, ctr_start, ctr_stop, ctr_up, ctr_down, evt_rej};

    count_session_ctrl #(
        .CNT_W     (CNT_W),
        .MAX_COUNT (MAX_COUNT)
`ifdef SESSION_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TMO_CYC)
`endif
    ) dut (
        .Clk100M    (Clk100M),
        .reset      (reset),
        .sess_start (sess_start),
        .sess_stop  (sess_stop),
        .a_req      (a_req),
        .a_dir      (a_dir),
        .a_ack      (a_ack),
        .b_req      (b_req),
        .b_dir      (b_dir),
        .b_ack      (b_ack),
        .ctr_start  (ctr_start),
        .ctr_stop   (ctr_stop),
        .ctr_up     (ctr_up),
        .ctr_down   (ctr_down),
        .sess_count (sess_count),
        .state      (state),
        .evt_rej    (evt_rej),
        .timed_out  (timed_out)
    );

    // clock / watchdog
    always #5 Clk100M = ~Clk100M;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks: inputs change on negedge, outputs are read on negedge
    task automatic pulse_start();
        sess_start = 1'b1;
        @(negedge Clk100M);
        sess_start = 1'b0;
    endtask

    task automatic pulse_stop();
        sess_stop = 1'b1;
        @(negedge Clk100M);
        sess_stop = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (state !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", state);
        end
        checks++;
        if ({pulses, sess_count, timed_out} !== '0) begin
            errors++; $display("FAIL reset_outputs: got pulses=%b count=%0d to=%b expected all 0", pulses, sess_count, timed_out);
        end
        repeat (2) @(negedge Clk100M);
        reset = 1'b0;
        pulse_stop();
        checks++;
        if (state !== 2'd0 || ctr_stop !== 1'b0) begin
            errors++; $display("FAIL idle_stop_ignored: got state=%0d ctr_stop=%b expected 0/0", state, ctr_stop);
        end
    endtask

    task automatic test_start();
        pulse_start();
        checks++;
        if (ctr_start !== 1'b1 || state !== 2'd1 || sess_count !== 8'd0) begin
            errors++; $display("FAIL start_armed: got start=%b state=%0d count=%0d expected 1/1/0", ctr_start, state, sess_count);
        end
        @(negedge Clk100M);
        checks++;
        if (ctr_start !== 1'b0 || state !== 2'd2) begin
            errors++; $display("FAIL start_active: got start=%b state=%0d expected 0/2", ctr_start, state);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] got, exp;
        int n;
        exp_q = {2'b01, 2'b10, 2'b01, 2'b10};
        n = 0;
        a_dir = 1'b1; b_dir = 1'b1;
        a_req = 1'b1; b_req = 1'b1;
        for (int cyc = 0; cyc < 8 && exp_q.size() > 0; cyc++) begin
            @(negedge Clk100M);
            got = {b_ack, a_ack};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp || ctr_up !== 1'b1 || evt_rej !== 1'b0) begin
                errors++; $display("FAIL rr_grant%0d: got ack=%b up=%b rej=%b expected ack=%b up=1 rej=0", n, got, ctr_up, evt_rej, exp);
            end
            n++;
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge Clk100M);
        checks++;
        if ({b_ack, a_ack} !== 2'b00 || sess_count !== 8'd4) begin
            errors++; $display("FAIL rr_count: got ack=%b count=%0d expected 00/4", {b_ack, a_ack}, sess_count);
        end
    endtask

    task automatic test_down_accept();
        b_dir = 1'b0; b_req = 1'b1;
        @(negedge Clk100M);
        b_req = 1'b0;
        checks++;
        if (b_ack !== 1'b1 || ctr_down !== 1'b1 || evt_rej !== 1'b0 || sess_count !== 8'd3) begin
            errors++; $display("FAIL down_accept: got ack=%b down=%b rej=%b count=%0d expected 1/1/0/3", b_ack, ctr_down, evt_rej, sess_count);
        end
        @(negedge Clk100M);
        checks++;
        if (b_ack !== 1'b0 || ctr_down !== 1'b0) begin
            errors++; $display("FAIL down_single_pulse: got ack=%b down=%b expected 0/0", b_ack, ctr_down);
        end
    endtask

    task automatic test_saturation();
        int acks, ups;
        acks = 0; ups = 0;
        a_dir = 1'b1; a_req = 1'b1;
        for (int cyc = 0; cyc < 1000 && acks < 252; cyc++) begin
            @(negedge Clk100M);
            if (a_ack) acks++;
            if (ctr_up) ups++;
            if (acks == 252) a_req = 1'b0;
        end
        a_req = 1'b0;
        checks++;
        if (ups !== 252 || sess_count !== 8'd255) begin
            errors++; $display("FAIL fill_to_max: got ups=%0d count=%0d expected 252/255", ups, sess_count);
        end
        @(negedge Clk100M);
        a_req = 1'b1;
        @(negedge Clk100M);
        a_req = 1'b0;
        checks++;
        if (a_ack !== 1'b1 || evt_rej !== 1'b1 || ctr_up !== 1'b0 || sess_count !== 8'd255) begin
            errors++; $display("FAIL sat_up: got ack=%b rej=%b up=%b count=%0d expected 1/1/0/255", a_ack, evt_rej, ctr_up, sess_count);
        end
        pulse_stop();
        checks++;
        if (ctr_stop !== 1'b1 || state !== 2'd3) begin
            errors++; $display("FAIL stop_done: got stop=%b state=%0d expected 1/3", ctr_stop, state);
        end
        pulse_start();
        @(negedge Clk100M);
        b_dir = 1'b0; b_req = 1'b1;
        @(negedge Clk100M);
        b_req = 1'b0;
        checks++;
        if (b_ack !== 1'b1 || evt_rej !== 1'b1 || ctr_down !== 1'b0 || sess_count !== 8'd0) begin
            errors++; $display("FAIL sat_down: got ack=%b rej=%b down=%b count=%0d expected 1/1/0/0", b_ack, evt_rej, ctr_down, sess_count);
        end
    endtask

    task automatic test_stop_start_same();
        a_dir = 1'b1; a_req = 1'b1;
        sess_stop = 1'b1; sess_start = 1'b1;
        @(negedge Clk100M);
        sess_stop = 1'b0; sess_start = 1'b0;
        checks++;
        if (ctr_stop !== 1'b1 || ctr_start !== 1'b0 || state !== 2'd3 || a_ack !== 1'b0) begin
            errors++; $display("FAIL stop_wins: got stop=%b start=%b state=%0d ack=%b expected 1/0/3/0", ctr_stop, ctr_start, state, a_ack);
        end
        @(negedge Clk100M);
        a_req = 1'b0;
        checks++;
        if (a_ack !== 1'b1 || evt_rej !== 1'b1 || ctr_stop !== 1'b0 || state !== 2'd3) begin
            errors++; $display("FAIL pending_after_stop: got ack=%b rej=%b stop=%b state=%0d expected 1/1/0/3", a_ack, evt_rej, ctr_stop, state);
        end
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        pulse_start();
        checks++;
        if (ctr_start !== 1'b1 || timed_out !== 1'b0) begin
            errors++; $display("FAIL tmo_start: got start=%b to=%b expected 1/0", ctr_start, timed_out);
        end
        @(negedge Clk100M);
        for (int k = 2; k <= TMO_CYC; k++) begin
            @(negedge Clk100M);
            if (state !== 2'd2 || ctr_stop !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL tmo_still_active: got %0d bad cycles expected 0", bad);
        end
        @(negedge Clk100M);
`ifdef SESSION_TIMEOUT_EN
        checks++;
        if (ctr_stop !== 1'b1 || timed_out !== 1'b1 || state !== 2'd3) begin
            errors++; $display("FAIL tmo_fire: got stop=%b to=%b state=%0d expected 1/1/3", ctr_stop, timed_out, state);
        end
        pulse_start();
        checks++;
        if (ctr_start !== 1'b1 || timed_out !== 1'b0) begin
            errors++; $display("FAIL tmo_clear: got start=%b to=%b expected 1/0", ctr_start, timed_out);
        end
`else
        checks++;
        if (ctr_stop !== 1'b0 || timed_out !== 1'b0 || state !== 2'd2) begin
            errors++; $display("FAIL no_timeout: got stop=%b to=%b state=%0d expected 0/0/2", ctr_stop, timed_out, state);
        end
        pulse_stop();
        pulse_start();
`endif
        @(negedge Clk100M);
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        a_dir = 1'b1; a_req = 1'b1;
        @(negedge Clk100M);
        checks++;
        if (a_ack !== 1'b1 || sess_count !== 8'd1 || state !== 2'd2) begin
            errors++; $display("FAIL mid_pre: got ack=%b count=%0d state=%0d expected 1/1/2", a_ack, sess_count, state);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (pulses !== '0 || sess_count !== 8'd0 || state !== 2'd0) begin
            errors++; $display("FAIL mid_reset_now: got pulses=%b count=%0d state=%0d expected 0/0/0", pulses, sess_count, state);
        end
        repeat (3) begin
            @(negedge Clk100M);
            if (a_ack !== 1'b0 || ctr_stop !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL mid_reset_hold: got %0d bad cycles expected 0", bad);
        end
        reset = 1'b0;
        @(negedge Clk100M);
        a_req = 1'b0;
        checks++;
        if (a_ack !== 1'b1 || evt_rej !== 1'b1 || ctr_stop !== 1'b0 || state !== 2'd0) begin
            errors++; $display("FAIL mid_post: got ack=%b rej=%b stop=%b state=%0d expected 1/1/0/0", a_ack, evt_rej, ctr_stop, state);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_round_robin();
        test_down_accept();
        test_saturation();
        test_stop_start_same();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_session_ctrl.md
Name: count_session_ctrl

Overview:
- Session controller and arbiter for the single up/down user counter.
- Sequences count sessions (start, active, stop or timeout) by driving the counter's start/stop/up/down inputs with one-cycle pulses.
- Shares the counter between two event requesters: A (front-panel buttons) and B (host/UART path), using req/ack handshakes.
- Keeps a saturating shadow count so no event can wrap the counter.

Parameters:
- CNT_W, 8, width of the shadow count; matches the counter's output width.
- MAX_COUNT, 255, upper saturation bound for the shadow count (≤ 2^CNT_W-1).
- TIMEOUT_CYCLES, 100000000, number of event-free ACTIVE cycles before auto-stop (1 s at 100 MHz).

Ports:
- Clk100M  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- sess_start  in  1  one-cycle pulse: begin a session.
- sess_stop  in  1  one-cycle pulse: end the session.
- a_req  in  1  requester A has an event pending (held until a_ack).
- a_dir  in  1  requester A direction, 1=up, 0=down; stable while a_req=1.
- a_ack  out  1  one-cycle pulse: A's event consumed.
- b_req  in  1  requester B event pending.
- b_dir  in  1  requester B direction.
- b_ack  out  1  one-cycle pulse: B's event consumed.
- ctr_start  out  1  pulse to counter start.
- ctr_stop  out  1  pulse to counter stop.
- ctr_up  out  1  pulse to counter up.
- ctr_down  out  1  pulse to counter down.
- sess_count  out  CNT_W  shadow count of applied events.
- state  out  2  FSM state encoding.
- evt_rej  out  1  pulse: an event was acked but discarded.
- timed_out  out  1  sticky; set when a session ends by timeout, cleared on the next start.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - All pulse outputs 0.
  - sess_count=0, timed_out=0, arbiter pointer = A, timer = 0.
- All outputs are registered; each pulse output is 1 for exactly 1 cycle.
- FSM encoding: IDLE=0, ARMED=1, ACTIVE=2, DONE=3.
- IDLE or DONE:
  - sess_start -> ARMED on the next edge.
  - In that same next cycle: ctr_start=1, sess_count=0, timed_out=0, timer=0.
  - sess_stop is ignored.
- ARMED: unconditionally -> ACTIVE after 1 cycle; no grants in ARMED.
- ACTIVE:
  - sess_stop -> DONE; ctr_stop=1 in the following cycle.
  - sess_stop wins over a simultaneous sess_start or request; the request stays pending.
  - sess_start while ACTIVE is ignored.
- Arbitration (ACTIVE only):
  - At most one grant per cycle.
  - Round-robin between A and B: after a grant, the pointer moves to the other requester.
  - Grant latency: request sampled at edge N; ack and ctr_up/ctr_down pulse in cycle N+1.
  - The granted requester's req is ignored during its ack cycle, so a held req is not double-granted.
- Saturation:
  - An up grant with sess_count==MAX_COUNT: ack=1, evt_rej=1, no ctr pulse, count unchanged.
  - A down grant with sess_count==0: same handling.
  - Otherwise sess_count ±1 together with the ctr pulse.
- Outside ACTIVE: pending requests are still arbitrated and acked, but discarded with evt_rej=1. Requesters never stall.
- Timer:
  - Reset to 0 by any accepted (non-rejected) grant.
  - Otherwise increments each ACTIVE cycle.
- Mid-operation reset: all state cleared; no ctr_stop is emitted.

Optional Feature:
- Macro: SESSION_TIMEOUT_EN.
- Defined:
  - When the timer reaches TIMEOUT_CYCLES-1 in ACTIVE, go to DONE with ctr_stop=1 and timed_out=1.
  - sess_stop on the same cycle also ends the session, but takes precedence, so timed_out stays 0.
- Undefined:
  - Timer logic is absent; sessions end only by sess_stop.
  - timed_out is tied to 0.

Decomposition:
- Package count_ctrl_pkg:
  - state typedef/localparams (IDLE, ARMED, ACTIVE, DONE).
  - DIR_UP=1, DIR_DOWN=0.
  - Arbiter pointer encoding.
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Output: one-hot grant[1:0].
  - Holds the pointer flop.
- Top level: FSM, timer, shadow count, pulse registers.

Test Plan:
- Reset then sess_start -> ctr_start pulse 1 cycle later; state goes ARMED then ACTIVE; sess_count=0.
- In ACTIVE, a_req and b_req both held with dir=1 for 4 grants -> acks alternate A, B, A, B; 4 ctr_up pulses; sess_count=4.
- Shadow count at 255, A up request -> a_ack=1, evt_rej=1, no ctr_up, count stays 255. Count at 0, B down -> same rejection.
- sess_stop and sess_start in the same ACTIVE cycle -> ctr_stop only; state=DONE; no ctr_start.
- SESSION_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no requests -> ctr_stop after 16 ACTIVE cycles; timed_out=1. Next sess_start clears it.
- Reset asserted mid-ACTIVE with a_req held -> outputs zero immediately; a_ack stays 0 while in reset. After release in IDLE, A is acked with evt_rej=1.
